// File: rtl/simd_regfile.sv
// Per-lane SIMD register file: 3 combinational read ports, 1 masked write port,
// hardwired-zero r0, write-to-read bypass and a multi-cycle clear sweep.
module simd_regfile #(
  parameter  int DW    = 16,
  parameter  int NREG  = 16,
  parameter  int NLANE = 4,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                Reset,
  input  logic [AW-1:0]       nA,
  input  logic [AW-1:0]       nB,
  input  logic [AW-1:0]       nC,
  output logic [NLANE*DW-1:0] A,
  output logic [NLANE*DW-1:0] B,
  output logic [NLANE*DW-1:0] C,
  input  logic [AW-1:0]       nD,
  input  logic [NLANE*DW-1:0] D,
  input  logic [NLANE-1:0]    WMask,
  input  logic                RegWE,
  input  logic                Clear,
  output logic                Busy
);

  localparam int W = NLANE * DW;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic [W-1:0]  mem_q [NREG];
  logic [W-1:0]  mem_d [NREG];

  logic [W-1:0]  lane_m;
  logic [W-1:0]  wr_data;
  logic          we;

  always_comb begin
    lane_m = '0;
    for (int k = 0; k < NLANE; k++) begin
      lane_m[k*DW +: DW] = {DW{WMask[k]}};
    end
  end

  assign we      = RegWE & ~busy_q & (nD != '0);
  assign wr_data = (D & lane_m) | (mem_q[nD] & ~lane_m);

  // Bypass reuses the merged write word: a matching index holds mem_q[nD].
  assign A = (nA == '0) ? '0 : (we && nA == nD) ? wr_data : mem_q[nA];
  assign B = (nB == '0) ? '0 : (we && nB == nD) ? wr_data : mem_q[nB];
  assign C = (nC == '0) ? '0 : (we && nC == nD) ? wr_data : mem_q[nC];

  assign Busy = busy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    mem_d   = mem_q;
    unique case (state_q)
      IDLE: begin
        if (we) begin
          mem_d[nD] = wr_data;
        end
        if (Clear) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        mem_d[idx_q] = '0;
        if (idx_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: tb/tb_simd_regfile.sv
// Scoreboard bench for simd_regfile: stimulus queues expected port values,
// a negedge monitor pops and compares them.
module tb_simd_regfile;

  localparam int DW = 16;
  localparam int NREG = 16;
  localparam int NLANE = 4;
  localparam int AW = 4;
  localparam int W = 64;

  localparam int PA = 0;
  localparam int PB = 1;
  localparam int PC = 2;
  localparam int PBUSY = 3;

  logic          clk;
  logic          Reset;
  logic [AW-1:0] nA, nB, nC, nD;
  logic [W-1:0]  A, B, C, D;
  logic [3:0]    WMask;
  logic          RegWE, Clear, Busy;

  typedef struct {
    string        name;
    int           port;
    logic [W-1:0] val;
  } item_t;

  item_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  simd_regfile #(.DW(DW), .NREG(NREG), .NLANE(NLANE)) dut (
    .clk(clk), .Reset(Reset),
    .nA(nA), .nB(nB), .nC(nC),
    .A(A), .B(B), .C(C),
    .nD(nD), .D(D), .WMask(WMask),
    .RegWE(RegWE), .Clear(Clear), .Busy(Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      item_t it;
      logic [W-1:0] act;
      it = sb.pop_front();
      case (it.port)
        PA: act = A;
        PB: act = B;
        PC: act = C;
        default: act = {{(W-1){1'b0}}, Busy};
      endcase
      n_cmp++;
      if (act !== it.val) begin
        n_err++;
        $display("FAIL %s: got %h want %h", it.name, act, it.val);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int p, input logic [W-1:0] v);
    sb.push_back('{nm, p, v});
  endtask

  function automatic logic [W-1:0] rep(input logic [15:0] x);
    return {4{x}};
  endfunction

  initial begin
    Reset = 1'b1;
    nA = '0; nB = '0; nC = '0; nD = '0;
    D = '0; WMask = '0; RegWE = 1'b0; Clear = 1'b0;
    cyc();
    cyc();
    Reset = 1'b0;

    // 1: reset state
    for (int i = 0; i < NREG; i++) begin
      nA = AW'(i);
      chk($sformatf("rst_r%0d", i), PA, '0);
      chk("rst_busy", PBUSY, 64'd1 - 64'd1);
      cyc();
    end

    // 2: full and masked write
    nD = 4'd3; D = 64'h4444_3333_2222_1111; WMask = 4'b1111; RegWE = 1'b1;
    nA = 4'd3;
    chk("wr3_bypass", PA, 64'h4444_3333_2222_1111);
    cyc();
    RegWE = 1'b0;
    chk("wr3_read", PA, 64'h4444_3333_2222_1111);
    cyc();
    RegWE = 1'b1; WMask = 4'b0101; D = rep(16'hFFFF);
    cyc();
    RegWE = 1'b0;
    chk("wr3_mask", PA, 64'h4444_FFFF_2222_FFFF);
    cyc();

    // 3: partial-mask bypass on port B
    RegWE = 1'b1; nD = 4'd5; nB = 4'd5; D = rep(16'hABCD); WMask = 4'b0011;
    chk("byp_b", PB, 64'h0000_0000_ABCD_ABCD);
    chk("byp_c_other", PC, '0);
    cyc();
    RegWE = 1'b0;
    chk("byp_b_stored", PB, 64'h0000_0000_ABCD_ABCD);
    cyc();

    // 4: r0 hardwired zero
    RegWE = 1'b1; nD = 4'd0; D = rep(16'h7777); WMask = 4'b1111; nA = 4'd0;
    chk("r0_same", PA, '0);
    cyc();
    RegWE = 1'b0;
    chk("r0_next", PA, '0);
    cyc();

    // 5: fill, then full clear sweep
    RegWE = 1'b1; WMask = 4'b1111;
    for (int i = 1; i < NREG; i++) begin
      nD = AW'(i); D = rep(16'(i));
      cyc();
    end
    RegWE = 1'b0; Clear = 1'b1; nA = 4'd15;
    chk("clr_busy0", PBUSY, '0);
    chk("fill_r15", PA, rep(16'h000F));
    cyc();
    Clear = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      chk($sformatf("sweep_busy%0d", i), PBUSY, 64'd1);
      if (i == 5) begin
        RegWE = 1'b1; nD = 4'd2; D = rep(16'h5A5A); nA = 4'd2; nB = 4'd10;
        chk("sweep_nobyp_r2", PA, '0);
        chk("sweep_r10_live", PB, rep(16'h000A));
      end else begin
        RegWE = 1'b0;
      end
      Clear = (i == 14);
      cyc();
    end
    RegWE = 1'b0; Clear = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      nA = AW'(i);
      chk("post_busy0", PBUSY, '0);
      chk($sformatf("post_r%0d", i), PA, '0);
      cyc();
    end

    // 6: Clear+RegWE same cycle, then Reset mid-sweep
    nD = 4'd4; D = rep(16'h0404); RegWE = 1'b1;
    cyc();
    nD = 4'd9; D = rep(16'h1234); RegWE = 1'b1; Clear = 1'b1;
    cyc();
    RegWE = 1'b0; Clear = 1'b0; nA = 4'd9; nB = 4'd4;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rst_sweep_busy%0d", i), PBUSY, 64'd1);
      chk("rst_sweep_r9", PA, rep(16'h1234));
      Reset = (i == 4);
      cyc();
    end
    Reset = 1'b0;
    chk("abort_busy0", PBUSY, '0);
    chk("abort_r9", PA, '0);
    chk("abort_r4", PB, '0);
    nD = 4'd7; D = rep(16'h0707); RegWE = 1'b1;
    cyc();
    RegWE = 1'b0; nA = 4'd7;
    chk("post_rst_r7", PA, rep(16'h0707));
    chk("post_rst_busy", PBUSY, '0);
    cyc();
    cyc();
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
